hangman_game_ctrl: RTL and testbench

//  Game sequencer downstream of the keypad letter FSM.
//  - Setter phase: collects a WORD_LEN-letter secret word.
//  - Guess phase: checks each guessed letter against the word, tracks hits and mistakes.
//  - Per guess: sends a 2-byte result (letter, status) to the radio/UART TX over a valid/ready handshake.

---
 rtl/hangman_pkg.sv | 34 +++
 rtl/hangman_letter_match.sv | 17 +
 rtl/hangman_game_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_hangman_game_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared constants and types for the hangman game sequencer.
package hangman_pkg;

    localparam logic [2:0] S_SET    = 3'd0;
    localparam logic [2:0] S_GUESS  = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_SEND_L = 3'd3;
    localparam logic [2:0] S_SEND_S = 3'd4;
    localparam logic [2:0] S_WIN    = 3'd5;
    localparam logic [2:0] S_LOSE   = 3'd6;

    typedef enum logic [2:0] {
        SET    = S_SET,
        GUESS  = S_GUESS,
        CHECK  = S_CHECK,
        SEND_L = S_SEND_L,
        SEND_S = S_SEND_S,
        WIN    = S_WIN,
        LOSE   = S_LOSE
    } ctrl_state_t;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;

    localparam int unsigned STATUS_WIN    = 7;
    localparam int unsigned STATUS_LOSE   = 6;
    localparam int unsigned STATUS_HIT    = 5;
    localparam int unsigned STATUS_REPEAT = 4;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

endpackage

// File: rtl/hangman_letter_match.sv
// Parallel compare of one guessed letter against every word position.
module hangman_letter_match #(
    parameter int unsigned WORD_LEN = 5
) (
    input  logic [WORD_LEN-1:0][7:0] word,
    input  logic [7:0]               guess,
    output logic [WORD_LEN-1:0]      hit
);

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < WORD_LEN; i++) begin
            hit[i] = (word[i] == guess);
        end
    end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game sequencer: word entry, guess checking and 2-byte result TX.
// Optional build macro REPEAT_GUESS_FILTER_EN: repeated guesses are flagged and not penalised.
module hangman_game_ctrl
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN     = 5,
    parameter int unsigned MAX_MISTAKES = 6
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic                letter_valid,
    input  logic [7:0]          letter,
    input  logic                word_submit,
    input  logic                game_end,
    input  logic                tx_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    output logic [3:0]          mistakes,
    output logic [WORD_LEN-1:0] correct_mask,
    output logic [2:0]          phase,
    output logic                win,
    output logic                lose
);

    localparam int unsigned    IDX_W    = $clog2(WORD_LEN + 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(WORD_LEN);
    localparam logic [3:0]     MIS_MAX  = 4'(MAX_MISTAKES);

    logic [2:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [WORD_LEN-1:0][7:0] word_q, word_d;
    logic [7:0]               guess_q, guess_d;
    logic [WORD_LEN-1:0]      mask_q, mask_d;
    logic [3:0]               mistakes_q, mistakes_d;
    logic                     hit_q, hit_d;
    logic                     rep_q, rep_d;
    logic                     end_pend_q, end_pend_d;
    logic                     win_q, win_d;
    logic                     lose_q, lose_d;
    logic                     tx_valid_q, tx_valid_d;
    logic [7:0]               tx_data_q, tx_data_d;

    logic [WORD_LEN-1:0]      hit_vec;
    logic                     rep_c;
    logic                     win_c;
    logic                     lose_c;
    logic                     end_c;
    logic                     clr;
    logic [7:0]               status_c;

`ifdef REPEAT_GUESS_FILTER_EN
    logic [25:0]              used_q, used_d;
    logic [4:0]               guess_ofs;

    assign guess_ofs = 5'(guess_q - ASCII_A);
    assign rep_c     = used_q[guess_ofs];
`else
    assign rep_c     = 1'b0;
`endif

    hangman_letter_match #(
        .WORD_LEN (WORD_LEN)
    ) u_match (
        .word  (word_q),
        .guess (guess_q),
        .hit   (hit_vec)
    );

    assign win_c  = &mask_q;
    assign lose_c = (mistakes_q == MIS_MAX);
    assign end_c  = end_pend_q | game_end;

    // Status byte reflects the already-updated mask and mistake count.
    always_comb begin
        status_c                = 8'h00;
        status_c[3:0]           = mistakes_q;
        status_c[STATUS_REPEAT] = rep_q;
        status_c[STATUS_HIT]    = hit_q;
        status_c[STATUS_LOSE]   = lose_c;
        status_c[STATUS_WIN]    = win_c;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        guess_d    = guess_q;
        mask_d     = mask_q;
        mistakes_d = mistakes_q;
        hit_d      = hit_q;
        rep_d      = rep_q;
        end_pend_d = end_pend_q;
        win_d      = win_q;
        lose_d     = lose_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
`ifdef REPEAT_GUESS_FILTER_EN
        used_d     = used_q;
`endif
        clr        = 1'b0;

        // Abort is immediate except while a byte is on the wire.
        if (game_end && (state_q != S_SEND_L) && (state_q != S_SEND_S)) begin
            clr = 1'b1;
        end else begin
            case (state_q)
                S_SET: begin
                    if (word_submit) begin
                        if (idx_q == IDX_FULL) begin
                            state_d    = S_GUESS;
                            mask_d     = '0;
                            mistakes_d = '0;
`ifdef REPEAT_GUESS_FILTER_EN
                            used_d     = '0;
`endif
                        end
                    end else if (letter_valid && is_upper(letter) && (idx_q < IDX_FULL)) begin
                        for (int unsigned i = 0; i < WORD_LEN; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                word_d[i] = letter;
                            end
                        end
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                S_GUESS: begin
                    if (letter_valid && is_upper(letter)) begin
                        guess_d = letter;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    mask_d = mask_q | hit_vec;
                    hit_d  = |hit_vec;
                    rep_d  = rep_c;
                    if (!(|hit_vec) && !rep_c && (mistakes_q < MIS_MAX)) begin
                        mistakes_d = mistakes_q + 4'd1;
                    end
`ifdef REPEAT_GUESS_FILTER_EN
                    used_d[guess_ofs] = 1'b1;
`endif
                    end_pend_d = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = guess_q;
                    state_d    = S_SEND_L;
                end
                S_SEND_L: begin
                    end_pend_d = end_c;
                    if (tx_ready) begin
                        if (end_c) begin
                            clr = 1'b1;
                        end else begin
                            tx_data_d = status_c;
                            state_d   = S_SEND_S;
                        end
                    end
                end
                S_SEND_S: begin
                    end_pend_d = end_c;
                    if (tx_ready) begin
                        if (end_c) begin
                            clr = 1'b1;
                        end else begin
                            tx_valid_d = 1'b0;
                            if (win_c) begin
                                win_d   = 1'b1;
                                state_d = S_WIN;
                            end else if (lose_c) begin
                                lose_d  = 1'b1;
                                state_d = S_LOSE;
                            end else begin
                                state_d = S_GUESS;
                            end
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    if (word_submit) begin
                        clr = 1'b1;
                    end
                end
                default: clr = 1'b1;
            endcase
        end

        // New game: everything back to the reset picture.
        if (clr) begin
            state_d    = S_SET;
            idx_d      = '0;
            word_d     = '0;
            guess_d    = '0;
            mask_d     = '0;
            mistakes_d = '0;
            hit_d      = 1'b0;
            rep_d      = 1'b0;
            end_pend_d = 1'b0;
            win_d      = 1'b0;
            lose_d     = 1'b0;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
`ifdef REPEAT_GUESS_FILTER_EN
            used_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q    <= S_SET;
            idx_q      <= '0;
            word_q     <= '0;
            guess_q    <= '0;
            mask_q     <= '0;
            mistakes_q <= '0;
            hit_q      <= 1'b0;
            rep_q      <= 1'b0;
            end_pend_q <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef REPEAT_GUESS_FILTER_EN
            used_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            guess_q    <= guess_d;
            mask_q     <= mask_d;
            mistakes_q <= mistakes_d;
            hit_q      <= hit_d;
            rep_q      <= rep_d;
            end_pend_q <= end_pend_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
`ifdef REPEAT_GUESS_FILTER_EN
            used_q     <= used_d;
`endif
        end
    end

    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign mistakes     = mistakes_q;
    assign correct_mask = mask_q;
    assign phase        = state_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Self-checking bench for hangman_game_ctrl against a letter-level game model.
module tb_hangman_game_ctrl;

    localparam int unsigned WL   = 5;
    localparam int unsigned MAXM = 6;

    localparam logic [2:0] P_SET   = 3'd0;
    localparam logic [2:0] P_GUESS = 3'd1;
    localparam logic [2:0] P_CHECK = 3'd2;
    localparam logic [2:0] P_WIN   = 3'd5;
    localparam logic [2:0] P_LOSE  = 3'd6;

    logic          clk = 1'b0;
    logic          Rst;
    logic          letter_valid;
    logic [7:0]    letter;
    logic          word_submit;
    logic          game_end;
    logic          tx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [3:0]    mistakes;
    logic [WL-1:0] correct_mask;
    logic [2:0]    phase;
    logic          win;
    logic          lose;

    int total = 0;
    int bad   = 0;

    // Reference game: the word, revealed positions, mistakes and used letters.
    logic [7:0]    m_word [WL];
    logic [WL-1:0] m_mask;
    int            m_mis;
    bit            m_used [26];
    bit            m_win;
    bit            m_lose;

    hangman_game_ctrl #(
        .WORD_LEN     (WL),
        .MAX_MISTAKES (MAXM)
    ) dut (
        .clk          (clk),
        .Rst          (Rst),
        .letter_valid (letter_valid),
        .letter       (letter),
        .word_submit  (word_submit),
        .game_end     (game_end),
        .tx_ready     (tx_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .mistakes     (mistakes),
        .correct_mask (correct_mask),
        .phase        (phase),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_letter(input logic [7:0] c);
        letter       = c;
        letter_valid = 1'b1;
        tick();
        letter_valid = 1'b0;
    endtask

    task automatic pulse_submit();
        word_submit = 1'b1;
        tick();
        word_submit = 1'b0;
    endtask

    task automatic pulse_end();
        game_end = 1'b1;
        tick();
        game_end = 1'b0;
    endtask

    function automatic logic [7:0] junk_char();
        case ($urandom_range(0, 3))
            0:       return 8'h40;
            1:       return 8'h5B;
            2:       return 8'h61 + 8'($urandom_range(0, 25));
            default: return 8'h30 + 8'($urandom_range(0, 9));
        endcase
    endfunction

    function automatic logic [7:0] rand_upper();
        return 8'h41 + 8'($urandom_range(0, 25));
    endfunction

    task automatic load_word(input logic [8*WL-1:0] s);
        for (int i = 0; i < WL; i++) m_word[i] = s[8*(WL-1-i) +: 8];
    endtask

    task automatic model_new_game();
        m_mask = '0;
        m_mis  = 0;
        m_win  = 1'b0;
        m_lose = 1'b0;
        for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
    endtask

    // Apply one guess to the model and produce the status byte it should send.
    task automatic model_guess(input logic [7:0] g, output logic [7:0] st);
        bit hit;
        bit rep;
        hit = 1'b0;
        rep = 1'b0;
        for (int i = 0; i < WL; i++) begin
            if (m_word[i] == g) begin
                m_mask[i] = 1'b1;
                hit       = 1'b1;
            end
        end
`ifdef REPEAT_GUESS_FILTER_EN
        rep = m_used[int'(g) - 65];
`endif
        if (!hit && !rep && m_mis < MAXM) m_mis++;
        m_used[int'(g) - 65] = 1'b1;
        m_win  = (m_mask == {WL{1'b1}});
        m_lose = (m_mis == MAXM);
        st = {m_win, m_lose, hit, rep, 4'(m_mis)};
    endtask

    // Enter m_word with junk mixed in, an early submit and an overflow letter.
    task automatic set_word();
        for (int i = 0; i < WL; i++) begin
            if ($urandom_range(0, 1) == 1) pulse_letter(junk_char());
            pulse_letter(m_word[i]);
            if (i == WL - 2) begin
                pulse_submit();
                total++;
                if (phase !== P_SET) begin
                    bad++;
                    $display("FAIL early_submit: phase=%0d want %0d", phase, P_SET);
                end
            end
        end
        pulse_letter(rand_upper());
        pulse_submit();
        model_new_game();
        total++;
        if (phase !== P_GUESS || correct_mask !== '0 || mistakes !== 4'd0) begin
            bad++;
            $display("FAIL word_submit: phase=%0d mask=%b mis=%0d want %0d/0/0",
                     phase, correct_mask, mistakes, P_GUESS);
        end
    endtask

    // Full guess round: latency, stalled letter byte, status byte, final state.
    task automatic do_guess(input logic [7:0] g, input int delay, output logic [7:0] st_got);
        logic [7:0] exp_st;
        logic [2:0] exp_ph;
        model_guess(g, exp_st);
        pulse_letter(g);
        total++;
        if (tx_valid !== 1'b0 || phase !== P_CHECK) begin
            bad++;
            $display("FAIL check_cycle: tx_valid=%b phase=%0d want 0/%0d", tx_valid, phase, P_CHECK);
        end
        tick();
        total++;
        if (tx_valid !== 1'b1 || tx_data !== g) begin
            bad++;
            $display("FAIL letter_byte: valid=%b data=%h want 1/%h", tx_valid, tx_data, g);
        end
        for (int d = 0; d < delay; d++) begin
            if ($urandom_range(0, 1) == 1) begin
                letter       = rand_upper();
                letter_valid = 1'b1;
            end
            tick();
            letter_valid = 1'b0;
            total++;
            if (tx_valid !== 1'b1 || tx_data !== g) begin
                bad++;
                $display("FAIL letter_hold: valid=%b data=%h want 1/%h", tx_valid, tx_data, g);
            end
        end
        tx_ready = 1'b1;
        tick();
        st_got = tx_data;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== exp_st) begin
            bad++;
            $display("FAIL status_byte: valid=%b data=%h want 1/%h", tx_valid, tx_data, exp_st);
        end
        tick();
        tx_ready = 1'b0;
        exp_ph = m_win ? P_WIN : (m_lose ? P_LOSE : P_GUESS);
        total++;
        if (phase !== exp_ph || correct_mask !== m_mask || mistakes !== 4'(m_mis) ||
            win !== m_win || lose !== m_lose || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_guess: ph=%0d mask=%b mis=%0d w=%b l=%b v=%b want %0d/%b/%0d/%b/%b/0",
                     phase, correct_mask, mistakes, win, lose, tx_valid,
                     exp_ph, m_mask, m_mis, m_win, m_lose);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick();
        tick();
        total++;
        if (phase !== P_SET || tx_valid !== 1'b0 || tx_data !== 8'h00 || mistakes !== 4'd0 ||
            correct_mask !== '0 || win !== 1'b0 || lose !== 1'b0) begin
            bad++;
            $display("FAIL reset: ph=%0d v=%b d=%h mis=%0d mask=%b w=%b l=%b want all 0",
                     phase, tx_valid, tx_data, mistakes, correct_mask, win, lose);
        end
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_hello();
        logic [7:0] st;
        load_word("HELLO");
        set_word();
        do_guess(8'h4C, 0, st);
        total++;
        if (st !== 8'h20 || correct_mask !== 5'b01100) begin
            bad++;
            $display("FAIL guess_L: st=%h mask=%b want 20/01100", st, correct_mask);
        end
        do_guess(8'h5A, 5, st);
        total++;
        if (st !== 8'h01) begin
            bad++;
            $display("FAIL guess_Z: st=%h want 01", st);
        end
        do_guess(8'h5A, 0, st);
        total++;
`ifdef REPEAT_GUESS_FILTER_EN
        if (st !== 8'h11 || mistakes !== 4'd1) begin
            bad++;
            $display("FAIL repeat_Z: st=%h mis=%0d want 11/1", st, mistakes);
        end
`else
        if (st !== 8'h02 || mistakes !== 4'd2) begin
            bad++;
            $display("FAIL repeat_Z: st=%h mis=%0d want 02/2", st, mistakes);
        end
`endif
        do_guess(8'h48, 1, st);
        do_guess(8'h45, 0, st);
        do_guess(8'h4F, 2, st);
        pulse_letter(8'h41);
        tick();
        total++;
        if (phase !== P_WIN || win !== 1'b1 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL win_hold: ph=%0d win=%b v=%b want %0d/1/0", phase, win, tx_valid, P_WIN);
        end
        pulse_submit();
        total++;
        if (phase !== P_SET || win !== 1'b0 || correct_mask !== '0 || mistakes !== 4'd0) begin
            bad++;
            $display("FAIL win_exit: ph=%0d win=%b mask=%b mis=%0d want 0/0/0/0",
                     phase, win, correct_mask, mistakes);
        end
    endtask

    task automatic test_lose();
        logic [7:0] st;
        logic [7:0] wrong [6];
        wrong = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h46, 8'h47};
        load_word("HELLO");
        set_word();
        for (int i = 0; i < 6; i++) do_guess(wrong[i], int'($urandom_range(0, 2)), st);
        total++;
        if (st !== 8'h46 || lose !== 1'b1) begin
            bad++;
            $display("FAIL lose_status: st=%h lose=%b want 46/1", st, lose);
        end
        for (int i = 0; i < 3; i++) pulse_letter(rand_upper());
        total++;
        if (phase !== P_LOSE || tx_valid !== 1'b0 || mistakes !== 4'd6) begin
            bad++;
            $display("FAIL lose_hold: ph=%0d v=%b mis=%0d want %0d/0/6", phase, tx_valid, mistakes, P_LOSE);
        end
        pulse_end();
        total++;
        if (phase !== P_SET || lose !== 1'b0 || mistakes !== 4'd0) begin
            bad++;
            $display("FAIL lose_exit: ph=%0d lose=%b mis=%0d want 0/0/0", phase, lose, mistakes);
        end
    endtask

    task automatic test_game_end();
        logic [7:0] st;
        load_word("HELLO");
        set_word();
        pulse_end();
        total++;
        if (phase !== P_SET) begin
            bad++;
            $display("FAIL end_in_guess: ph=%0d want 0", phase);
        end
        load_word("WORLD");
        set_word();
        letter       = 8'h51;
        letter_valid = 1'b1;
        tick();
        letter_valid = 1'b0;
        game_end     = 1'b1;
        tick();
        game_end     = 1'b0;
        total++;
        if (phase !== P_SET || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL end_in_check: ph=%0d v=%b want 0/0", phase, tx_valid);
        end
        load_word("WORLD");
        set_word();
        pulse_letter(8'h51);
        tick();
        pulse_end();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h51) begin
                bad++;
                $display("FAIL end_pending_hold: v=%b d=%h want 1/51", tx_valid, tx_data);
            end
            tick();
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        total++;
        if (phase !== P_SET || tx_valid !== 1'b0 || mistakes !== 4'd0 || correct_mask !== '0) begin
            bad++;
            $display("FAIL end_after_accept: ph=%0d v=%b mis=%0d mask=%b want 0/0/0/0",
                     phase, tx_valid, mistakes, correct_mask);
        end
        load_word("ABCDE");
        set_word();
        do_guess(8'h43, 0, st);
        total++;
        if (correct_mask !== 5'b00100) begin
            bad++;
            $display("FAIL new_word_after_end: mask=%b want 00100", correct_mask);
        end
        pulse_end();
    endtask

    task automatic test_mid_reset();
        load_word("QUART");
        set_word();
        pulse_letter(8'h51);
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        total++;
        if (phase !== P_SET || tx_valid !== 1'b0 || correct_mask !== '0) begin
            bad++;
            $display("FAIL mid_reset: ph=%0d v=%b mask=%b want 0/0/0", phase, tx_valid, correct_mask);
        end
    endtask

    task automatic test_random_games();
        logic [7:0] st;
        logic [7:0] g;
        int         n;
        for (int game = 0; game < 6; game++) begin
            for (int i = 0; i < WL; i++) m_word[i] = rand_upper();
            set_word();
            n = 0;
            while (!m_win && !m_lose && n < 60) begin
                if ($urandom_range(0, 3) == 0) pulse_letter(junk_char());
                if ($urandom_range(0, 1) == 1) g = m_word[$urandom_range(0, WL - 1)];
                else g = rand_upper();
                do_guess(g, int'($urandom_range(0, 3)), st);
                n++;
            end
            if (m_win || m_lose) pulse_submit();
            else pulse_end();
            total++;
            if (phase !== P_SET || win !== 1'b0 || lose !== 1'b0) begin
                bad++;
                $display("FAIL random_game_exit: ph=%0d w=%b l=%b want 0/0/0", phase, win, lose);
            end
        end
    endtask

    initial begin
        Rst          = 1'b1;
        letter_valid = 1'b0;
        letter       = 8'h00;
        word_submit  = 1'b0;
        game_end     = 1'b0;
        tx_ready     = 1'b0;
        model_new_game();
        test_reset();
        test_hello();
        test_lose();
        test_game_end();
        test_mid_reset();
        test_random_games();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
